// File: rtl/dffram_pkg.sv
// dffram_pkg: shared definitions for the dffram_1rw1r scratchpad macro.
//   BYTE_W       - width of one write lane
//   addr_width() - address width for a given word count, never below 1
//   merge_lanes()- byte-lane merge used by both the storage write path and
//                  the port-1 forwarding path, so both agree bit-for-bit
package dffram_pkg;

  localparam int BYTE_W = 8;

  // Widest word the merge helper handles. Callers zero-extend their word
  // into word_max_t and truncate the result back to their own width.
  localparam int MAX_BYTES = 64;

  typedef logic [MAX_BYTES*BYTE_W-1:0] word_max_t;
  typedef logic [MAX_BYTES-1:0]        lane_mask_t;

  function automatic int addr_width(input int words);
    int w;
    w = $clog2(words);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  // Lanes with mask=1 take new_w, the rest keep old_w.
  function automatic word_max_t merge_lanes(input word_max_t  old_w,
                                            input word_max_t  new_w,
                                            input lane_mask_t mask);
    word_max_t r;
    r = old_w;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (mask[b]) begin
        r[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dffram_1rw1r_if.sv
// dffram_1rw1r_if: bus bundle for the two RAM ports.
//   EN0/WE0/A0/Di0 -> port 0 request (read/write), Do0 <- port 0 read data
//   EN1/A1         -> port 1 request (read only),  Do1 <- port 1 read data
// master: the bus wrapper / requester side. slave: the RAM.
interface dffram_1rw1r_if
  import dffram_pkg::*;
#(
  parameter int WSIZE  = 4,
  parameter int AWIDTH = 7
);

  logic                      EN0;
  logic [WSIZE-1:0]          WE0;
  logic [AWIDTH-1:0]         A0;
  logic [WSIZE*BYTE_W-1:0]   Di0;
  logic [WSIZE*BYTE_W-1:0]   Do0;
  logic                      EN1;
  logic [AWIDTH-1:0]         A1;
  logic [WSIZE*BYTE_W-1:0]   Do1;

  modport master (
    output EN0, WE0, A0, Di0, EN1, A1,
    input  Do0, Do1
  );

  modport slave (
    input  EN0, WE0, A0, Di0, EN1, A1,
    output Do0, Do1
  );

endinterface

// File: rtl/dffram_word.sv
// dffram_word: one WSIZE-byte flip-flop storage word.
//   CLK     - clock
//   wmask_i - per-lane write enable (already qualified by word select)
//   wdata_i - write data
//   word_o  - stored word
// Storage is deliberately not reset; contents survive RST.
module dffram_word
  import dffram_pkg::*;
#(
  parameter int WSIZE = 4
)(
  input  logic                    CLK,
  input  logic [WSIZE-1:0]        wmask_i,
  input  logic [WSIZE*BYTE_W-1:0] wdata_i,
  output logic [WSIZE*BYTE_W-1:0] word_o
);

  localparam int WW = WSIZE * BYTE_W;

  logic [WW-1:0] word_q;
  logic [WW-1:0] word_d;

  assign word_d = WW'(merge_lanes(word_max_t'(word_q),
                                  word_max_t'(wdata_i),
                                  lane_mask_t'(wmask_i)));

  always_ff @(posedge CLK) begin
    if (|wmask_i) begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/dffram_1rw1r.sv
// dffram_1rw1r: flip-flop RAM with one read/write port and one read port.
//   CLK - clock, RST - synchronous active-high reset (outputs/pipeline only)
//   bus - dffram_1rw1r_if slave:
//     port 0: EN0, WE0 (byte enables), A0, Di0 -> Do0 (read-first)
//     port 1: EN1, A1 -> Do1 (sees port 0's same-edge write to the same word)
// Read latency is 1 cycle, or 2 with OUT_REG=1. Addresses >= WORDS read as
// zero and are never written, so there is no aliasing onto real words.
module dffram_1rw1r
  import dffram_pkg::*;
#(
  parameter int WSIZE   = 4,
  parameter int WORDS   = 128,
  parameter int OUT_REG = 0,
  parameter int AWIDTH  = addr_width(WORDS)
)(
  input  logic CLK,
  input  logic RST,
  dffram_1rw1r_if.slave bus
);

  localparam int WW = WSIZE * BYTE_W;

  logic [WW-1:0] word_rd [WORDS];
  logic [WW-1:0] rd0_word;
  logic [WW-1:0] rd1_word;
  logic [WW-1:0] rd1_fwd;
  logic          a0_ok;
  logic          fwd_hit;
  logic [WW-1:0] do0_q, do0_d;
  logic [WW-1:0] do1_q, do1_d;

  assign a0_ok = (int'(bus.A0) < WORDS);

  // Storage words. A decoded match can only happen for an in-range address,
  // so out-of-range writes fall away without extra gating. RST blocks writes.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic word_sel;
      assign word_sel = bus.EN0 && !RST && (bus.A0 == AWIDTH'(gi));

      dffram_word #(.WSIZE(WSIZE)) u_word (
        .CLK     (CLK),
        .wmask_i ({WSIZE{word_sel}} & bus.WE0),
        .wdata_i (bus.Di0),
        .word_o  (word_rd[gi])
      );
    end
  endgenerate

  // Read muxes; an address that matches no word yields zero.
  always_comb begin
    rd0_word = '0;
    rd1_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (bus.A0 == AWIDTH'(i)) begin
        rd0_word = word_rd[i];
      end
      if (bus.A1 == AWIDTH'(i)) begin
        rd1_word = word_rd[i];
      end
    end
  end

  // Port 1 is write-first against port 0: merge the lanes being written this
  // edge. Out-of-range addresses never forward, otherwise Di0 bytes would
  // leak into a read that must return zero.
  assign fwd_hit = bus.EN0 && a0_ok && (bus.A0 == bus.A1);
  assign rd1_fwd = fwd_hit ? WW'(merge_lanes(word_max_t'(rd1_word),
                                             word_max_t'(bus.Di0),
                                             lane_mask_t'(bus.WE0)))
                           : rd1_word;

  assign do0_d = bus.EN0 ? rd0_word : do0_q;
  assign do1_d = bus.EN1 ? rd1_fwd  : do1_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      do0_q <= '0;
      do1_q <= '0;
    end else begin
      do0_q <= do0_d;
      do1_q <= do1_d;
    end
  end

  // Optional second stage: free-running copy of the first stage.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WW-1:0] do0_p_q;
      logic [WW-1:0] do1_p_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          do0_p_q <= '0;
          do1_p_q <= '0;
        end else begin
          do0_p_q <= do0_q;
          do1_p_q <= do1_q;
        end
      end

      assign bus.Do0 = do0_p_q;
      assign bus.Do1 = do1_p_q;
    end else begin : g_no_out_reg
      assign bus.Do0 = do0_q;
      assign bus.Do1 = do1_q;
    end
  endgenerate

endmodule

// File: tb/tb_dffram_1rw1r.sv
module tb_dffram_1rw1r;
  import dffram_pkg::*;

  localparam int NW = 100;

  logic        clk;
  logic        rst;
  logic        en0;
  logic [3:0]  we0;
  logic [6:0]  a0;
  logic [31:0] di0;
  logic        en1;
  logic [6:0]  a1;

  int n_cmp;
  int n_fail;

  // Reference model: word array plus the value each port "should show"
  // after one edge (s1) and after two edges (s2).
  logic [31:0] mem_m [NW];
  logic [31:0] m_s1_0, m_s1_1, m_s2_0, m_s2_1;

  dffram_1rw1r_if #(.WSIZE(4), .AWIDTH(7)) bus0 ();
  dffram_1rw1r_if #(.WSIZE(4), .AWIDTH(7)) bus1 ();

  assign bus0.EN0 = en0;  assign bus1.EN0 = en0;
  assign bus0.WE0 = we0;  assign bus1.WE0 = we0;
  assign bus0.A0  = a0;   assign bus1.A0  = a0;
  assign bus0.Di0 = di0;  assign bus1.Di0 = di0;
  assign bus0.EN1 = en1;  assign bus1.EN1 = en1;
  assign bus0.A1  = a1;   assign bus1.A1  = a1;

  dffram_1rw1r #(.WSIZE(4), .WORDS(NW), .OUT_REG(0), .AWIDTH(7)) u_dut0 (
    .CLK(clk), .RST(rst), .bus(bus0));
  dffram_1rw1r #(.WSIZE(4), .WORDS(NW), .OUT_REG(1), .AWIDTH(7)) u_dut1 (
    .CLK(clk), .RST(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock edge: drive inputs, let the model react to the edge, then
  // settle to the falling edge where outputs are sampled.
  task automatic tick(input logic r, input logic e0, input logic [3:0] w,
                      input logic [6:0] a0v, input logic [31:0] d,
                      input logic e1, input logic [6:0] a1v);
    logic [31:0] rd0, rd1;
    rst = r; en0 = e0; we0 = w; a0 = a0v; di0 = d; en1 = e1; a1 = a1v;
    @(posedge clk);
    if (r) begin
      m_s1_0 = '0; m_s1_1 = '0; m_s2_0 = '0; m_s2_1 = '0;
    end else begin
      m_s2_0 = m_s1_0;
      m_s2_1 = m_s1_1;
      // Port 0 sees memory before this edge's write.
      rd0 = (a0v < NW) ? mem_m[a0v] : 32'h0;
      if (e0 && a0v < NW) begin
        for (int b = 0; b < 4; b++) begin
          if (w[b]) mem_m[a0v][8*b +: 8] = d[8*b +: 8];
        end
      end
      // Port 1 sees memory after this edge's write.
      rd1 = (a1v < NW) ? mem_m[a1v] : 32'h0;
      if (e0) m_s1_0 = rd0;
      if (e1) m_s1_1 = rd1;
    end
    @(negedge clk);
    $display("tick rst=%0b en0=%0b we0=%h a0=%h di0=%h en1=%0b a1=%h | r0:%h/%h r1:%h/%h",
             r, e0, w, a0v, d, e1, a1v, bus0.Do0, bus0.Do1, bus1.Do0, bus1.Do1);
  endtask

  task automatic test_reset();
    tick(1, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    for (int i = 0; i < NW; i++) begin
      tick(0, 1, 4'hF, 7'(i), 32'h1000_0000 + 32'(i), 0, 7'h0);
    end
    // Reset with both ports enabled and a full write attempted.
    tick(1, 1, 4'hF, 7'h05, 32'hFFFF_FFFF, 1, 7'h05);
    tick(1, 1, 4'hF, 7'h05, 32'hFFFF_FFFF, 1, 7'h05);
    n_cmp++; if (bus0.Do0 !== 32'h0) begin n_fail++; $display("FAIL rst_r0_do0: got %h want 00000000", bus0.Do0); end
    n_cmp++; if (bus0.Do1 !== 32'h0) begin n_fail++; $display("FAIL rst_r0_do1: got %h want 00000000", bus0.Do1); end
    n_cmp++; if (bus1.Do0 !== 32'h0) begin n_fail++; $display("FAIL rst_r1_do0: got %h want 00000000", bus1.Do0); end
    n_cmp++; if (bus1.Do1 !== 32'h0) begin n_fail++; $display("FAIL rst_r1_do1: got %h want 00000000", bus1.Do1); end
    // Word 5 must still hold its fill value.
    tick(0, 1, 4'h0, 7'h05, 32'h0, 1, 7'h05);
    n_cmp++; if (bus0.Do0 !== 32'h1000_0005) begin n_fail++; $display("FAIL rst_nowrite_r0_do0: got %h want 10000005", bus0.Do0); end
    n_cmp++; if (bus0.Do1 !== 32'h1000_0005) begin n_fail++; $display("FAIL rst_nowrite_r0_do1: got %h want 10000005", bus0.Do1); end
    n_cmp++; if (bus1.Do0 !== 32'h0) begin n_fail++; $display("FAIL rst_lat_r1_do0: got %h want 00000000", bus1.Do0); end
    tick(0, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus1.Do0 !== 32'h1000_0005) begin n_fail++; $display("FAIL rst_nowrite_r1_do0: got %h want 10000005", bus1.Do0); end
    n_cmp++; if (bus1.Do1 !== 32'h1000_0005) begin n_fail++; $display("FAIL rst_nowrite_r1_do1: got %h want 10000005", bus1.Do1); end
  endtask

  task automatic test_byte_lanes();
    tick(0, 1, 4'hF, 7'h00, 32'hAA00_55BB, 0, 7'h0);
    tick(0, 1, 4'h4, 7'h00, 32'h0033_0000, 0, 7'h0);
    tick(0, 1, 4'h0, 7'h00, 32'h0, 1, 7'h00);
    n_cmp++; if (bus0.Do0 !== 32'hAA33_55BB) begin n_fail++; $display("FAIL lanes_r0_do0: got %h want aa3355bb", bus0.Do0); end
    n_cmp++; if (bus0.Do1 !== 32'hAA33_55BB) begin n_fail++; $display("FAIL lanes_r0_do1: got %h want aa3355bb", bus0.Do1); end
    // Two-stage part still shows the read made by the previous write edge.
    n_cmp++; if (bus1.Do0 !== 32'hAA00_55BB) begin n_fail++; $display("FAIL lanes_lat_r1_do0: got %h want aa0055bb", bus1.Do0); end
    tick(0, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus1.Do0 !== 32'hAA33_55BB) begin n_fail++; $display("FAIL lanes_r1_do0: got %h want aa3355bb", bus1.Do0); end
    n_cmp++; if (bus1.Do1 !== 32'hAA33_55BB) begin n_fail++; $display("FAIL lanes_r1_do1: got %h want aa3355bb", bus1.Do1); end
    n_cmp++; if (bus0.Do0 !== 32'hAA33_55BB) begin n_fail++; $display("FAIL lanes_hold_r0_do0: got %h want aa3355bb", bus0.Do0); end
  endtask

  task automatic test_forwarding();
    tick(0, 1, 4'hF, 7'h11, 32'hAA00_55CC, 0, 7'h0);
    tick(0, 1, 4'h2, 7'h11, 32'h0000_3300, 1, 7'h11);
    n_cmp++; if (bus0.Do1 !== 32'hAA00_33CC) begin n_fail++; $display("FAIL fwd_r0_do1: got %h want aa0033cc", bus0.Do1); end
    n_cmp++; if (bus0.Do0 !== 32'hAA00_55CC) begin n_fail++; $display("FAIL fwd_r0_do0: got %h want aa0055cc", bus0.Do0); end
    tick(0, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus1.Do1 !== 32'hAA00_33CC) begin n_fail++; $display("FAIL fwd_r1_do1: got %h want aa0033cc", bus1.Do1); end
    n_cmp++; if (bus1.Do0 !== 32'hAA00_55CC) begin n_fail++; $display("FAIL fwd_r1_do0: got %h want aa0055cc", bus1.Do0); end
  endtask

  task automatic test_out_of_range();
    tick(0, 1, 4'hF, 7'h0C, 32'hCAFE_F00D, 0, 7'h0);
    tick(0, 1, 4'hF, 7'h70, 32'h1234_5678, 0, 7'h0);
    tick(0, 1, 4'h0, 7'h70, 32'h0, 1, 7'h0C);
    n_cmp++; if (bus0.Do0 !== 32'h0) begin n_fail++; $display("FAIL oor_r0_do0: got %h want 00000000", bus0.Do0); end
    n_cmp++; if (bus0.Do1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oor_alias_r0_do1: got %h want cafef00d", bus0.Do1); end
    tick(0, 1, 4'hF, 7'h70, 32'h5555_5555, 1, 7'h70);
    n_cmp++; if (bus0.Do1 !== 32'h0) begin n_fail++; $display("FAIL oor_nofwd_r0_do1: got %h want 00000000", bus0.Do1); end
    n_cmp++; if (bus1.Do0 !== 32'h0) begin n_fail++; $display("FAIL oor_r1_do0: got %h want 00000000", bus1.Do0); end
    n_cmp++; if (bus1.Do1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oor_alias_r1_do1: got %h want cafef00d", bus1.Do1); end
    tick(0, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus1.Do1 !== 32'h0) begin n_fail++; $display("FAIL oor_nofwd_r1_do1: got %h want 00000000", bus1.Do1); end
  endtask

  task automatic test_hold();
    tick(0, 1, 4'hF, 7'h12, 32'hAA00_5533, 0, 7'h0);
    tick(0, 0, 4'h0, 7'h0, 32'h0, 1, 7'h12);
    n_cmp++; if (bus0.Do1 !== 32'hAA00_5533) begin n_fail++; $display("FAIL hold_read_r0_do1: got %h want aa005533", bus0.Do1); end
    tick(0, 1, 4'hF, 7'h12, 32'hFFFF_FFFF, 0, 7'h12);
    n_cmp++; if (bus0.Do1 !== 32'hAA00_5533) begin n_fail++; $display("FAIL hold_r0_do1: got %h want aa005533", bus0.Do1); end
    n_cmp++; if (bus1.Do1 !== 32'hAA00_5533) begin n_fail++; $display("FAIL hold_r1_do1: got %h want aa005533", bus1.Do1); end
    tick(0, 1, 4'h0, 7'h12, 32'h0, 1, 7'h12);
    n_cmp++; if (bus0.Do1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL hold_reread_r0_do1: got %h want ffffffff", bus0.Do1); end
    n_cmp++; if (bus0.Do0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL raw_prev_r0_do0: got %h want ffffffff", bus0.Do0); end
    tick(0, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus1.Do1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL hold_reread_r1_do1: got %h want ffffffff", bus1.Do1); end
  endtask

  task automatic test_reset_mid();
    tick(0, 1, 4'hF, 7'h10, 32'hAA00_55BB, 0, 7'h0);
    tick(0, 1, 4'h0, 7'h00, 32'h0, 0, 7'h0);
    tick(0, 1, 4'h0, 7'h10, 32'h0, 0, 7'h0);
    tick(1, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus0.Do0 !== 32'h0) begin n_fail++; $display("FAIL midrst_r0_do0: got %h want 00000000", bus0.Do0); end
    n_cmp++; if (bus1.Do0 !== 32'h0) begin n_fail++; $display("FAIL midrst_r1_do0: got %h want 00000000", bus1.Do0); end
    tick(0, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus1.Do0 !== 32'h0) begin n_fail++; $display("FAIL midrst_stale_r1_do0: got %h want 00000000", bus1.Do0); end
    tick(0, 1, 4'h0, 7'h10, 32'h0, 0, 7'h0);
    n_cmp++; if (bus0.Do0 !== 32'hAA00_55BB) begin n_fail++; $display("FAIL midrst_after_r0_do0: got %h want aa0055bb", bus0.Do0); end
    n_cmp++; if (bus1.Do0 !== 32'h0) begin n_fail++; $display("FAIL midrst_lat_r1_do0: got %h want 00000000", bus1.Do0); end
    tick(0, 0, 4'h0, 7'h0, 32'h0, 0, 7'h0);
    n_cmp++; if (bus1.Do0 !== 32'hAA00_55BB) begin n_fail++; $display("FAIL midrst_after_r1_do0: got %h want aa0055bb", bus1.Do0); end
  endtask

  task automatic test_random();
    logic        r, e0, e1;
    logic [3:0]  w;
    logic [6:0]  x0, x1;
    logic [31:0] d;
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 59) == 0);
      e0 = 1'($urandom);
      e1 = 1'($urandom);
      w  = 4'($urandom);
      d  = $urandom;
      x0 = 7'($urandom_range(0, 109));
      x1 = ($urandom_range(0, 2) == 0) ? x0 : 7'($urandom_range(0, 127));
      tick(r, e0, w, x0, d, e1, x1);
      n_cmp++; if (bus0.Do0 !== m_s1_0) begin n_fail++; $display("FAIL rand_r0_do0 c=%0d: got %h want %h", c, bus0.Do0, m_s1_0); end
      n_cmp++; if (bus0.Do1 !== m_s1_1) begin n_fail++; $display("FAIL rand_r0_do1 c=%0d: got %h want %h", c, bus0.Do1, m_s1_1); end
      n_cmp++; if (bus1.Do0 !== m_s2_0) begin n_fail++; $display("FAIL rand_r1_do0 c=%0d: got %h want %h", c, bus1.Do0, m_s2_0); end
      n_cmp++; if (bus1.Do1 !== m_s2_1) begin n_fail++; $display("FAIL rand_r1_do1 c=%0d: got %h want %h", c, bus1.Do1, m_s2_1); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1; en0 = 1'b0; we0 = '0; a0 = '0; di0 = '0; en1 = 1'b0; a1 = '0;
    m_s1_0 = '0; m_s1_1 = '0; m_s2_0 = '0; m_s2_1 = '0;
    @(negedge clk);
    test_reset();
    test_byte_lanes();
    test_forwarding();
    test_out_of_range();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dffram_1rw1r.md
Name: dffram_1rw1r

Overview:
- Parametrised successor to the single-port DFF RAM macro.
- Memory array is flip-flop based, with byte-granular write enables.
- Port 0 is read/write; port 1 is a second, independent read-only port.
- Adds synchronous output reset, write-to-read forwarding between ports, and an optional output pipeline stage.
- Sits behind the bus wrapper as a scratchpad/register-file macro.

Parameters:
- WSIZE, 4, bytes per word; data width is WSIZE*8.
- WORDS, 128, number of words; need not be a power of two; must be >= 2.
- OUT_REG, 0, 0 = read data registered once; 1 = one extra output register stage.
- AWIDTH, $clog2(WORDS), derived address width; not overridden.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- EN0  in  1  port 0 enable; gates both read and write.
- WE0  in  WSIZE  port 0 byte write enables; bit i writes Di0[8i+7:8i].
- A0  in  AWIDTH  port 0 address.
- Di0  in  WSIZE*8  port 0 write data.
- Do0  out  WSIZE*8  port 0 read data.
- EN1  in  1  port 1 read enable.
- A1  in  AWIDTH  port 1 address.
- Do1  out  WSIZE*8  port 1 read data.

Behaviour:
- Reset: Do0, Do1 and all pipeline registers are 0 on the edge where RST=1. Memory contents are not reset. RST overrides EN0/EN1: no write or read occurs on a reset edge.
- Write: at a rising edge with EN0=1 and WE0[i]=1, byte i of mem[A0] is set to Di0 byte i. Lanes with WE0[i]=0 are unchanged.
- Port 0 read (read-first):
  - At a rising edge with EN0=1, the read stage loads the old mem[A0], i.e. the value before this edge's write.
  - The read happens whether or not WE0 is nonzero.
- Port 1 read (write-first forwarding):
  - At a rising edge with EN1=1, the read stage loads mem[A1].
  - If EN0=1 and A0==A1 on the same edge, lanes with WE0[i]=1 take Di0 byte i; the other lanes take the stored bytes.
- Latency:
  - OUT_REG=0: data appears on Do0/Do1 after the edge that sampled EN/A (1 cycle).
  - OUT_REG=1: a second register stage adds 1 cycle (2 cycles total). That stage updates every cycle and carries the first stage value forward.
- Hold: when ENx=0, the first-stage register for port x holds its previous value. With OUT_REG=1, the output settles to that held value after one more edge.
- Out of range (A >= WORDS):
  - Writes are dropped; no wrap-around aliasing.
  - Reads return all zeros.
  - Forwarding is suppressed for out-of-range addresses.
- Simultaneous events:
  - Both ports may address the same word on the same edge; the rules above apply.
  - Port 0 read of an address written on the previous edge returns the new data.
- Reset mid-operation: in-flight pipeline data is discarded. The first valid read data after RST falls appears at the normal latency after the first enabled edge.
- Address and data inputs are don't-care when the port enable is 0.

Decomposition:
- Package dffram_pkg:
  - function for address width (clog2 with a minimum of 1);
  - constant BYTE_W = 8;
  - helper for byte-lane merge, (old, new, mask) -> word, shared by the write path and the forwarding path.
- Sub-module dffram_word: one WSIZE-byte storage word.
  - Inputs: CLK, a per-lane write mask (the word select ANDed with WE0), write data.
  - Output: stored word.
  - Instantiated WORDS times under generate.
- Top level holds: the address decode, two read multiplexers, forwarding compare, output registers and the OUT_REG generate.

Test Plan:
- Each scenario below is run for both OUT_REG=0 and OUT_REG=1, with latency checked for each.
- Reset: with RST=1 for 2 cycles and EN0=EN1=1 → Do0=Do1=0x00000000. No write occurs even with WE0=4'b1111.
- Byte lanes, port 0:
  - Write 0x00: AA0055BB (mask 1111).
  - Write 0x00: 00330000 (mask 0100).
  - Read 0x00 → Do0=0xAA3355BB after the configured latency.
  - Read 0x00 on port 1 → Do1=0xAA3355BB.
- Forwarding:
  - mem[0x11]=0xAA0055CC.
  - On the same edge: port 0 writes 0x11 with 0x00003300, mask 0010; port 1 reads 0x11.
  - Required: Do1=0xAA0033CC, and a port 0 read on that edge returns 0xAA0055CC.
- Out of range with WORDS=100:
  - Write 0x70: 12345678.
  - Then read 0x70 → 0x00000000.
  - Read 0x70-100 wrap alias 0x0C (preloaded 0xCAFEF00D) → 0xCAFEF00D, unchanged.
- Hold and independence:
  - Port 1 reads 0x12 (=0xAA005533), then EN1=0 while port 0 writes 0x12 with 0xFFFFFFFF.
  - Do1 stays 0xAA005533.
  - Next EN1=1 read → 0xFFFFFFFF.
- Reset mid-pipeline, OUT_REG=1:
  - Issue a read of 0x10, then RST=1 on the next edge.
  - Do0=0 afterwards; the stale 0xAA0055BB never appears on Do0.
